// File: rtl/mips_step_ctrl_pkg.sv
// Shared definitions for the front-panel step controller.
//   state_t  : controller states (S_STEP / S_RUN / S_HALT)
//   K_*      : index of each KEY button within key_n / key_db / key_press
package mips_step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_STEP = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam int K_STEP   = 0;  // single-step the core
  localparam int K_LOAD   = 1;  // used by the core for program load
  localparam int K_CLR    = 2;  // leave the HALT state
  localparam int K_RUN    = 3;  // toggle free-running mode
  localparam int NUM_KEYS = 4;

endpackage

// File: rtl/mips_step_ctrl_key_debounce.sv
// One pushbutton conditioner: 2-flop synchroniser, hold-time debounce
// counter and a one-cycle press pulse.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low reset
//   key_n      in   raw button, 0 = pressed, asynchronous and bouncy
//   key_db     out  debounced level, 1 = pressed
//   key_press  out  one-cycle pulse the cycle after key_db rises
module mips_step_ctrl_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_db,
  output logic key_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          db_reg;
  logic          db_prev_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;
  logic          synced;

  // Polarity flips here: from this point on 1 means pressed.
  assign synced = ~sync2_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      db_reg      <= 1'b0;
      db_prev_reg <= 1'b0;
      press_reg   <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      // Any return to the accepted level restarts the hold timer, so bounce
      // shorter than DEBOUNCE_CYCLES never produces an event.
      if (synced != db_reg) begin
        if (cnt_reg == CNT_LAST) begin
          db_reg  <= synced;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
      // Pulse lands one cycle after key_db rises; releases never pulse.
      db_prev_reg <= db_reg;
      press_reg   <= db_reg & ~db_prev_reg;
    end
  end

  assign key_db    = db_reg;
  assign key_press = press_reg;

endmodule

// File: rtl/mips_step_ctrl.sv
// Front-panel execution controller for the single-cycle MIPS core.
// Conditions the four KEY buttons, issues the PC-advance strobe either per
// KEY0 press or at a fixed rate in RUN mode, and latches a HALT state.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   key_n[3:0]  in   raw buttons, 0 = pressed
//   run_sw      in   1 allows RUN mode; 0 forces step-only operation
//   fast_sw     in   1 selects the RUN_DIV/16 step period
//   halt        in   stop condition reported by the core
//   key_db      out  debounced levels, 1 = pressed
//   key_press   out  one-cycle press pulses
//   step        out  one-cycle PC-advance strobe
//   running     out  1 while in S_RUN
//   halted      out  1 while in S_HALT
//   step_count  out  number of step pulses issued (wrapping)
module mips_step_ctrl
  import mips_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_n,
  input  logic             run_sw,
  input  logic             fast_sw,
  input  logic             halt,
  output logic [3:0]       key_db,
  output logic [3:0]       key_press,
  output logic             step,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_LAST =
      DIV_W'((RUN_DIV / 16 > 1) ? (RUN_DIV / 16 - 1) : 0);

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic             step_reg;
  logic [CNT_W-1:0] count_reg;
  logic [DIV_W-1:0] div_last;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      mips_step_ctrl_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n[gi]),
        .key_db   (key_db[gi]),
        .key_press(key_press[gi])
      );
    end
  endgenerate

  // Re-evaluated every cycle: dropping to the fast limit while the divider
  // is already past it makes the >= compare fire on the next cycle.
  assign div_last = fast_sw ? FAST_LAST : SLOW_LAST;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_STEP;
      div_reg   <= '0;
      step_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      step_reg <= 1'b0;
      if (step_reg) begin
        count_reg <= count_reg + CNT_W'(1);
      end
      case (state_reg)
        S_STEP: begin
          if (halt) begin
            state_reg <= S_HALT;
          end else if (key_press[K_RUN] && run_sw) begin
            state_reg <= S_RUN;
            div_reg   <= '0;
          end else begin
            step_reg <= key_press[K_STEP];
          end
        end
        S_RUN: begin
          if (halt) begin
            state_reg <= S_HALT;
          end else if (key_press[K_RUN] || !run_sw) begin
            state_reg <= S_STEP;
          end else if (div_reg >= div_last) begin
            step_reg <= 1'b1;
            div_reg  <= '0;
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
        S_HALT: begin
          // If halt is still asserted, S_STEP drops straight back here.
          if (key_press[K_CLR]) begin
            state_reg <= S_STEP;
          end
        end
        default: state_reg <= S_STEP;
      endcase
    end
  end

  assign step       = step_reg;
  assign step_count = count_reg;
  assign running    = (state_reg == S_RUN);
  assign halted     = (state_reg == S_HALT);

endmodule
